perf_counter_ctrl: RTL and testbench
====================================

Name: perf_counter_ctrl

Overview:
- Control and readout sequencer for the core's performance counter bank: cycles, instructions, branches, branch_misses and stalls.
- Owns the per-counter inhibit mask and the bank-wide clear.
- Serves 32-bit CSR reads of 64-bit counters with an atomic lo/hi pair.
- Runs a snapshot-and-dump engine that streams a coherent copy of all counters over a valid/ready port to the trace/debug sink.

Parameters:
- NUM_COUNTERS, 5, number of counters in the bank; index order is cycles, instructions, branches, branch_misses, stalls.
- CNT_W, PERF_COUNTER_WIDTH (64), width of each counter.
- DATA_W, 32, CSR and stream word width; CNT_W must equal 2*DATA_W.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- counter_values  in  NUM_COUNTERS*CNT_W  live counter values, counter i at bits [i*CNT_W +: CNT_W].
- count_enable  out  NUM_COUNTERS  per-counter enable to the bank; equals ~inhibit.
- counter_clear  out  1  one-cycle clear pulse to the bank.
- csr_re  in  1  CSR read strobe.
- csr_we  in  1  CSR write strobe.
- csr_addr  in  4  CSR register index.
- csr_wdata  in  DATA_W  CSR write data.
- csr_rdata  out  DATA_W  CSR read data.
- csr_rvalid  out  1  read data valid.
- dump_req  in  1  pulse that starts a dump.
- dump_busy  out  1  high while a dump is in progress (SNAP or SEND).
- out_valid  out  1  stream data valid.
- out_ready  in  1  stream sink ready.
- out_data  out  DATA_W  stream word.
- out_idx  out  4  counter index of the current word.
- out_last  out  1  marks the final word of a dump.

Behaviour:
- Reset (asynchronous, active-low), all registers cleared:
  - inhibit=0, so count_enable is all ones.
  - counter_clear=0, csr_rvalid=0, csr_rdata=0, hi_latch=0.
  - FSM in IDLE; out_valid=0, out_data=0, out_idx=0, out_last=0, dump_busy=0.
- CSR map:
  - 0x0..NUM_COUNTERS-1: read the lo half of counter i; the same cycle loads hi_latch with that counter's hi half.
  - 0x8: read hi_latch (read-only).
  - 0xE: inhibit mask, read/write, NUM_COUNTERS bits, upper bits read 0.
  - 0xF: control, write-only, reads 0. Bit0 write-one fires counter_clear for exactly one cycle. Bit1 write-one starts a dump, equivalent to dump_req.
  - Unmapped addresses: read 0; writes ignored.
- CSR read latency:
  - csr_rvalid rises exactly 1 cycle after csr_re, with csr_rdata registered alongside it.
  - csr_rvalid is low on every other cycle.
- CSR access rules:
  - csr_re and csr_we in the same cycle: the write takes effect; the read returns the pre-write value.
  - Writes to the inhibit mask update count_enable on the next cycle.
- Dump FSM, states IDLE, SNAP, SEND:
  - IDLE -> SNAP on dump_req or a control bit1 write (both at once counts as one dump).
  - SNAP (1 cycle): copies all of counter_values into snapshot registers.
  - SEND: emits 2*NUM_COUNTERS words in order lo0, hi0, lo1, hi1, ... out_idx is the counter index; out_last=1 on the final hi word.
  - A word transfers when out_valid && out_ready. out_valid is asserted from the cycle after SNAP.
  - out_data, out_idx and out_last must stay stable while out_valid && !out_ready.
  - After the last transfer the FSM returns to IDLE and out_valid drops in the following cycle, unless a new dump starts.
  - dump_busy is high during SNAP and SEND.
- Boundary conditions:
  - dump_req while busy: ignored, not queued.
  - counter_clear during SEND: snapshot unaffected; the streamed data are pre-clear values.
  - Inhibit changes during a dump: allowed; no effect on the snapshot.
  - Reset mid-dump: FSM returns to IDLE and out_valid=0 asynchronously; no partial resume.
  - Word counter runs 0..2*NUM_COUNTERS-1 with no wrap beyond that.

Decomposition:
- riscv_pkg holds:
  - PERF_COUNTER_WIDTH and NUM_PERF_COUNTERS.
  - The CSR offset constants PERF_CSR_HI=4'h8, PERF_CSR_INHIBIT=4'hE and PERF_CSR_CTRL=4'hF.
  - The perf_dump_state_t enum {IDLE, SNAP, SEND}.
- One natural sub-module: perf_dump_streamer. It contains the snapshot registers, the SEND FSM and the valid/ready output stage.
- The top level keeps the CSR decode, inhibit mask, clear pulse and hi_latch.

Test Plan:
- Reset deasserted with counter_values cycles=64'h1_0000_0005: csr_re addr 0 gives csr_rdata=5 one cycle later; a following read of addr 8 gives 1 even though the live counter has since changed.
- Write 0xE=5'b00110 -> next cycle count_enable=5'b11001; reading 0xE returns 6.
- Write 0xF=1 -> counter_clear high for exactly 1 cycle; a read of 0xF returns 0.
- dump_req with out_ready=1, instructions=64'hA_0000_000B:
  - 10 words follow, starting the cycle after SNAP; words 2 and 3 are B then A with out_idx=1.
  - out_last only on word 9; dump_busy drops after the final transfer.
- Dump with out_ready toggling 1/0 plus a second dump_req mid-stream: outputs hold while stalled, the second request is ignored, and exactly 10 transfers occur.
- Reset asserted mid-SEND at word 4: out_valid=0 immediately; after release, a new dump restarts at word 0 with fresh snapshot values.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the performance counter control slice.
package riscv_pkg;

  localparam int PERF_COUNTER_WIDTH = 64;
  localparam int NUM_PERF_COUNTERS  = 5;
  localparam int PERF_DATA_W        = 32;

  // CSR register offsets inside the perf counter window.
  localparam logic [3:0] PERF_CSR_HI      = 4'h8;
  localparam logic [3:0] PERF_CSR_INHIBIT = 4'hE;
  localparam logic [3:0] PERF_CSR_CTRL    = 4'hF;

  // Dump engine states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    SEND = 2'd2
  } perf_dump_state_t;

endpackage

// File: rtl/perf_dump_streamer.sv
// Snapshot-and-dump engine: captures all counters in one cycle, then streams
// lo0, hi0, lo1, hi1, ... over a valid/ready port.
//
// Handshake: a word transfers on a cycle where out_valid && out_ready; while
// out_valid && !out_ready, out_data/out_idx/out_last hold their values.
module perf_dump_streamer
  import riscv_pkg::*;
#(
  parameter int NUM_COUNTERS = NUM_PERF_COUNTERS,
  parameter int CNT_W        = PERF_COUNTER_WIDTH,
  parameter int DATA_W       = PERF_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_COUNTERS*CNT_W-1:0] counter_values,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [3:0]                    out_idx,
  output logic                          out_last,
  output perf_dump_state_t              state
);

  localparam logic [3:0] LAST_WORD = 4'(2*NUM_COUNTERS-1);

  perf_dump_state_t              state_q, state_d;
  logic [NUM_COUNTERS*CNT_W-1:0] snap_q;
  logic [3:0]                    word_q;
  logic                          fire;

  // The snapshot is laid out lo0,hi0,lo1,hi1,... so word n sits at n*DATA_W.
  assign out_valid = (state_q == SEND);
  assign out_data  = snap_q[word_q*DATA_W +: DATA_W];
  assign out_idx   = {1'b0, word_q[3:1]};
  assign out_last  = (word_q == LAST_WORD);
  assign fire      = out_valid && out_ready;
  assign state     = state_q;

  // State register; reset abandons any dump in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start requests outside IDLE are dropped, not queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SNAP;
      SNAP:    state_d = SEND;
      SEND:    if (fire && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Coherent copy of the whole bank taken in the SNAP cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                snap_q <= '0;
    else if (state_q == SNAP)  snap_q <= counter_values;
  end

  // Word pointer: cleared on SNAP, advances per transfer, back to 0 after last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                word_q <= '0;
    else if (state_q == SNAP)  word_q <= '0;
    else if (fire)             word_q <= out_last ? 4'd0 : word_q + 4'd1;
  end

endmodule

// File: rtl/perf_counter_ctrl.sv
// Performance counter bank control: CSR decode, inhibit mask, bank clear,
// atomic lo/hi readout via hi_latch, and the dump streamer.
module perf_counter_ctrl
  import riscv_pkg::*;
#(
  parameter int NUM_COUNTERS = NUM_PERF_COUNTERS,
  parameter int CNT_W        = PERF_COUNTER_WIDTH,
  parameter int DATA_W       = PERF_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_COUNTERS*CNT_W-1:0] counter_values,
  output logic [NUM_COUNTERS-1:0]       count_enable,
  output logic                          counter_clear,
  input  logic                          csr_re,
  input  logic                          csr_we,
  input  logic [3:0]                    csr_addr,
  input  logic [DATA_W-1:0]             csr_wdata,
  output logic [DATA_W-1:0]             csr_rdata,
  output logic                          csr_rvalid,
  input  logic                          dump_req,
  output logic                          dump_busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [3:0]                    out_idx,
  output logic                          out_last
);

  localparam logic [3:0] NUM_CNT_4 = 4'(NUM_COUNTERS);

  logic [NUM_COUNTERS-1:0] inhibit_q;
  logic [DATA_W-1:0]       hi_latch_q;
  logic [DATA_W-1:0]       rd_next;
  logic [DATA_W-1:0]       hi_next;
  logic                    cnt_sel;
  logic                    wr_inhibit;
  logic                    wr_ctrl;
  logic                    dump_start;
  perf_dump_state_t        dump_state;
  logic                    unused_wdata;

  assign cnt_sel      = (csr_addr < NUM_CNT_4);
  assign wr_inhibit   = csr_we && (csr_addr == PERF_CSR_INHIBIT);
  assign wr_ctrl      = csr_we && (csr_addr == PERF_CSR_CTRL);
  assign dump_start   = dump_req || (wr_ctrl && csr_wdata[1]);
  assign count_enable = ~inhibit_q;
  assign dump_busy    = (dump_state != IDLE);
  assign unused_wdata = ^csr_wdata[DATA_W-1:NUM_COUNTERS];

  // Read mux on current (pre-write) register state.
  always_comb begin
    rd_next = '0;
    hi_next = '0;
    if (cnt_sel) begin
      rd_next = counter_values[int'(csr_addr)*CNT_W +: DATA_W];
      hi_next = counter_values[int'(csr_addr)*CNT_W + DATA_W +: DATA_W];
    end else if (csr_addr == PERF_CSR_HI) begin
      rd_next = hi_latch_q;
    end else if (csr_addr == PERF_CSR_INHIBIT) begin
      rd_next[NUM_COUNTERS-1:0] = inhibit_q;
    end
  end

  // Registered read response; a lo read also latches the matching hi half.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csr_rvalid <= 1'b0;
      csr_rdata  <= '0;
      hi_latch_q <= '0;
    end else begin
      csr_rvalid <= csr_re;
      if (csr_re) begin
        csr_rdata <= rd_next;
        if (cnt_sel) hi_latch_q <= hi_next;
      end
    end
  end

  // Inhibit mask register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          inhibit_q <= '0;
    else if (wr_inhibit) inhibit_q <= csr_wdata[NUM_COUNTERS-1:0];
  end

  // Single-cycle clear pulse on a control bit0 write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) counter_clear <= 1'b0;
    else        counter_clear <= wr_ctrl && csr_wdata[0];
  end

  perf_dump_streamer #(
    .NUM_COUNTERS (NUM_COUNTERS),
    .CNT_W        (CNT_W),
    .DATA_W       (DATA_W)
  ) u_streamer (
    .clk            (clk),
    .reset          (reset),
    .start          (dump_start),
    .counter_values (counter_values),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_idx        (out_idx),
    .out_last       (out_last),
    .state          (dump_state)
  );

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Directed bench for perf_counter_ctrl: CSR reads/writes, clear pulse, dumps
// with and without back-pressure, and reset in the middle of a dump.
module tb_perf_counter_ctrl;

  localparam int N = 5;

  logic            clk;
  logic            reset;
  logic [N*64-1:0] counter_values;
  logic [N-1:0]    count_enable;
  logic            counter_clear;
  logic            csr_re;
  logic            csr_we;
  logic [3:0]      csr_addr;
  logic [31:0]     csr_wdata;
  logic [31:0]     csr_rdata;
  logic            csr_rvalid;
  logic            dump_req;
  logic            dump_busy;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_data;
  logic [3:0]      out_idx;
  logic            out_last;

  logic [63:0] vals [N];
  logic [63:0] snap [N];
  int          checks = 0;
  int          errors = 0;
  int          n;

  perf_counter_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .counter_values (counter_values),
    .count_enable   (count_enable),
    .counter_clear  (counter_clear),
    .csr_re         (csr_re),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .csr_rvalid     (csr_rvalid),
    .dump_req       (dump_req),
    .dump_busy      (dump_busy),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_idx        (out_idx),
    .out_last       (out_last)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    counter_values = '0;
    for (int i = 0; i < N; i++) counter_values[i*64 +: 64] = vals[i];
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int w);
    logic [63:0] v;
    v = snap[w/2];
    return (w % 2 == 1) ? v[63:32] : v[31:0];
  endfunction

  task automatic chk_word(input string tag, input int w);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, exp_word(w));
    chk({tag, "_idx"}, out_idx, 4'(w/2));
    chk({tag, "_last"}, out_last, (w == 2*N-1));
  endtask

  task automatic take_snap;
    for (int i = 0; i < N; i++) snap[i] = vals[i];
  endtask

  initial begin
    // Reset
    reset = 1'b0; csr_re = 0; csr_we = 0; csr_addr = 0; csr_wdata = 0;
    dump_req = 0; out_ready = 0;
    vals[0] = 64'h1_0000_0005;
    vals[1] = 64'h1111_2222_3333_4444;
    vals[2] = 64'h5555_6666_7777_8888;
    vals[3] = 64'h9999_AAAA_BBBB_CCCC;
    vals[4] = 64'hDDDD_EEEE_FFFF_0001;
    #1;
    chk("rst_count_enable", count_enable, 5'h1F);
    chk("rst_counter_clear", counter_clear, 1'b0);
    chk("rst_rvalid", csr_rvalid, 1'b0);
    chk("rst_rdata", csr_rdata, 32'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_idx", out_idx, 4'h0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_dump_busy", dump_busy, 1'b0);
    tick; tick;
    reset = 1'b1;

    // Lo read latches hi; hi read returns latched value
    csr_re = 1; csr_addr = 4'h0;
    tick;
    chk("rd_lo_valid", csr_rvalid, 1'b1);
    chk("rd_lo_data", csr_rdata, 32'h5);
    csr_addr = 4'h8;
    vals[0] = 64'h2_0000_0007;
    tick;
    chk("rd_hi_valid", csr_rvalid, 1'b1);
    chk("rd_hi_data", csr_rdata, 32'h1);
    csr_addr = 4'h5;
    tick;
    chk("rd_unmapped", csr_rdata, 32'h0);
    csr_re = 0;
    tick;
    chk("rvalid_low", csr_rvalid, 1'b0);

    // Inhibit write and readback
    csr_we = 1; csr_addr = 4'hE; csr_wdata = 32'h6;
    tick;
    chk("inhibit_enable", count_enable, 5'b11001);
    csr_we = 0; csr_re = 1;
    tick;
    chk("inhibit_read", csr_rdata, 32'h6);
    // Read and write together: read sees the old value
    csr_we = 1; csr_wdata = 32'hFFFF_FFFF;
    tick;
    chk("rw_same_rdata", csr_rdata, 32'h6);
    chk("rw_same_enable", count_enable, 5'b00000);
    csr_re = 0; csr_wdata = 32'h0;
    tick;
    chk("inhibit_cleared", count_enable, 5'h1F);

    // Clear pulse
    csr_we = 1; csr_addr = 4'hF; csr_wdata = 32'h1;
    tick;
    chk("clear_high", counter_clear, 1'b1);
    chk("clear_no_dump", dump_busy, 1'b0);
    csr_we = 0; csr_re = 1;
    tick;
    chk("clear_low", counter_clear, 1'b0);
    chk("ctrl_read", csr_rdata, 32'h0);
    csr_re = 0;
    tick;

    // Dump with ready=1; mid-dump clear, inhibit and value changes
    vals[1] = 64'hA_0000_000B;
    out_ready = 1; dump_req = 1;
    take_snap;
    tick;
    chk("d1_snap_busy", dump_busy, 1'b1);
    chk("d1_snap_valid", out_valid, 1'b0);
    dump_req = 0;
    for (int w = 0; w < 2*N; w++) begin
      tick;
      chk_word("d1_word", w);
      chk("d1_busy", dump_busy, 1'b1);
      if (w == 5) begin
        csr_we = 1; csr_addr = 4'hF; csr_wdata = 32'h1;
        vals[2] = 64'h0; vals[3] = 64'h0;
      end else if (w == 6) begin
        csr_addr = 4'hE; csr_wdata = 32'h3;
      end else begin
        csr_we = 0;
      end
    end
    chk("d1_w2_data", exp_word(2), 32'hB);
    tick;
    chk("d1_done_valid", out_valid, 1'b0);
    chk("d1_done_busy", dump_busy, 1'b0);
    chk("d1_inhibit", count_enable, 5'b11100);

    // Back-pressured dump, started by dump_req and ctrl bit1 together
    out_ready = 0;
    csr_we = 1; csr_addr = 4'hF; csr_wdata = 32'h2; dump_req = 1;
    take_snap;
    tick;
    chk("d2_snap_busy", dump_busy, 1'b1);
    csr_we = 0; dump_req = 0;
    tick;
    n = 0;
    for (int c = 0; c < 60 && n < 2*N; c++) begin
      chk_word("d2_word", n);
      if (c == 3) vals[0] = 64'hDEAD_BEEF_0000_1234;
      dump_req = (c == 6);
      out_ready = (c % 2 == 1);
      if (out_ready) n++;
      tick;
    end
    dump_req = 0; out_ready = 1;
    chk("d2_xfers", n, 2*N);
    chk("d2_done_valid", out_valid, 1'b0);
    chk("d2_done_busy", dump_busy, 1'b0);
    tick;
    chk("d2_not_queued", dump_busy, 1'b0);

    // Reset in the middle of a dump
    dump_req = 1;
    take_snap;
    tick;
    dump_req = 0;
    for (int w = 0; w <= 4; w++) begin
      tick;
      if (w == 4) chk_word("d3_word", w);
    end
    reset = 0;
    #1;
    chk("d3_rst_valid", out_valid, 1'b0);
    chk("d3_rst_busy", dump_busy, 1'b0);
    #1;
    reset = 1;
    tick;
    chk("d3_rst_enable", count_enable, 5'h1F);
    vals[0] = 64'h0123_4567_89AB_CDEF;
    vals[4] = 64'hCAFE_0000_F00D_0042;
    dump_req = 1;
    take_snap;
    tick;
    dump_req = 0;
    for (int w = 0; w < 2*N; w++) begin
      tick;
      chk_word("d4_word", w);
    end
    tick;
    chk("d4_done_valid", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
